edge_test_array: RTL and testbench
==================================

EDGE_TEST_ARRAY -- requirements
Module: edge_test_array

Interface
REQ-001 Parameter LANES, default 4, meaning horizontally adjacent pixels tested per beat (1..16).
REQ-002 Parameter CW, default 16, meaning signed vertex coordinate width.
REQ-003 Parameter XW, default 11, meaning unsigned pixel x width; YW, default 10, meaning unsigned pixel y width.
REQ-004 clk  in  1  clock; rst  in  1  reset, synchronous, active-low.
REQ-005 tri_valid  in  1  triangle offered; tri_ready  out  1  triangle accepted when both high.
REQ-006 tri_data  in  6*CW  {p1x,p1y,p2x,p2y,p3x,p3y}, p1x in the MSBs, each signed.
REQ-007 cull_mode  in  2  0 = both windings, 1 = CCW only (area>0), 2 = CW only (area<0), 3 = treated as 0; sampled with tri_data.
REQ-008 pix_valid  in  1; pix_ready  out  1; pix_x  in  XW  lane-0 x; pix_y  in  YW; pix_mask  in  LANES  lane enables; pix_last  in  1  final beat of the current triangle.
REQ-009 out_valid  out  1; out_ready  in  1; out_x  out  XW; out_y  out  YW; out_inside  out  LANES  per-lane hit; out_last  out  1.
REQ-010 busy  out  1  high whenever state is not IDLE.

Function
REQ-011 States IDLE, SETUP, ACTIVE, DRAIN; tri_ready = 1 only in IDLE.
REQ-012 IDLE -> SETUP on tri_valid; tri_data and cull_mode are registered on that edge.
REQ-013 SETUP lasts exactly 1 cycle: edge deltas ab, bc, ca (CW+1 bits signed), 2*area = ab.x*(-ca.y) - ab.y*(-ca.x) at full width, degenerate = (area == 0), culled = cull_mode rejects sign(area); SETUP -> ACTIVE unconditionally.
REQ-014 pix_ready = (state == ACTIVE) && !stall, where stall = out_valid && !out_ready.
REQ-015 ACTIVE -> DRAIN on an accepted beat with pix_last = 1; no further beats accepted.
REQ-016 DRAIN -> IDLE in the cycle the last beat's output is consumed (out_valid && out_ready && out_last).
REQ-017 Lane k tests pixel (pix_x + k, pix_y); x addition at XW+1 bits, no wrap.
REQ-018 Per lane, for each edge (ab,bp), (bc,cp), (ca,ap): E = d.x*v.y - d.y*v.x, products 2*(CW+1) bits, difference one bit wider; no truncation anywhere.
REQ-019 Pipeline stage 1 registers the six products per lane; stage 2 registers the sign compare and output fields.
REQ-020 Latency exactly 2 cycles from accepted beat to out_valid when no stall.
REQ-021 out_inside[k] = pix_mask[k] && !degenerate && !culled && ((all E >= 0) || (all E <= 0)); E == 0 counts as inside (edge-inclusive).
REQ-022 Degenerate or culled triangles still consume and emit every beat, with out_inside = 0.
REQ-023 During stall, both pipeline stages and all outputs hold; no beat is lost or duplicated.
REQ-024 out_x, out_y, out_last equal the accepted beat's pix_x, pix_y, pix_last.
REQ-025 Beats are emitted in acceptance order.
REQ-026 The pipeline holds at most 2 beats.
REQ-027 out_valid deasserts the cycle after the final handshake when no new beat is in flight.

Reset
REQ-028 While rst = 0 at a clock edge: state = IDLE, out_valid = 0, out_x = 0, out_y = 0, out_inside = 0, out_last = 0.
REQ-029 Also under reset: tri_ready = 0, pix_ready = 0, busy = 0, pipeline valid bits cleared.
REQ-030 Reset asserted mid-triangle discards all in-flight beats; after release, tri_ready = 1 on the first cycle.

Verification
REQ-031 LANES=4; tri (0,0),(8,0),(0,8), cull 0; beat x=0,y=0, mask 1111, last -> out_inside=1111 two cycles after accept, out_last=1, busy low one cycle later.
REQ-032 Same triangle; beat x=6,y=2, mask 1011 -> lanes x=6,7,9: E checks give 1, 0, 0, so out_inside=0001 (x=8 masked off).
REQ-033 Vertical line (5,0),(5,4),(5,9), any beat -> out_inside=0000, all beats still emitted.
REQ-034 CW triangle (0,0),(0,8),(8,0) with cull_mode=1 -> out_inside=0000; with cull_mode=0 and beat x=1,y=1 -> 1111.
REQ-035 Hold out_ready=0 for 5 cycles with 3 beats offered -> only 2 accepted, pix_ready=0; outputs stable; on release the beats emerge in order, unchanged.
REQ-036 rst=0 asserted while in ACTIVE with 2 beats in flight -> out_valid=0 next cycle, no stale beat is emitted after release, and a fresh triangle is accepted.

Source files
------------

// File: rtl/edge_test_array.sv
// Multi-lane triangle edge-function tester.
// Setup computes deltas and area; a 2-stage pipeline tests LANES pixels per beat.
module edge_test_array #(
  parameter int LANES = 4,
  parameter int CW    = 16,
  parameter int XW    = 11,
  parameter int YW    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tri_valid,
  output logic                tri_ready,
  input  logic [6*CW-1:0]     tri_data,
  input  logic [1:0]          cull_mode,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [XW-1:0]       pix_x,
  input  logic [YW-1:0]       pix_y,
  input  logic [LANES-1:0]    pix_mask,
  input  logic                pix_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XW-1:0]       out_x,
  output logic [YW-1:0]       out_y,
  output logic [LANES-1:0]    out_inside,
  output logic                out_last,
  output logic                busy
);

  // Delta width, pixel-vector width, product, edge and area widths.
  localparam int DW  = CW + 1;
  localparam int VW0 = (CW > XW + 2) ? CW : XW + 2;
  localparam int VW1 = (VW0 > YW + 1) ? VW0 : YW + 1;
  localparam int VW  = VW1 + 1;
  localparam int PW  = DW + VW;
  localparam int EW  = PW + 1;
  localparam int AW  = 2 * DW + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic signed [CW-1:0] ax, ay, bx, by, cx, cy;
  logic [1:0]           cmode;

  logic signed [DW-1:0] sab_x, sab_y, sbc_x, sbc_y, sca_x, sca_y;
  logic signed [DW:0]   nca_x, nca_y;
  logic signed [AW-1:0] area2;
  logic                 culled_c;

  logic signed [DW-1:0] ab_x, ab_y, bc_x, bc_y, ca_x, ca_y;
  logic                 degenerate, culled;

  logic tri_fire, pix_fire, stall, out_fire;

  logic signed [PW-1:0] prod [LANES][6];
  logic signed [PW-1:0] s1_p [LANES][6];
  logic                 s1_v;
  logic [XW-1:0]        s1_x;
  logic [YW-1:0]        s1_y;
  logic [LANES-1:0]     s1_mask;
  logic                 s1_last;
  logic [LANES-1:0]     inside_c;

  assign tri_fire = tri_valid && tri_ready;
  assign pix_fire = pix_valid && pix_ready;
  assign stall    = out_valid && !out_ready;
  assign out_fire = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (tri_valid) state_nx = SETUP;
      SETUP:  state_nx = ACTIVE;
      ACTIVE: if (pix_fire && pix_last) state_nx = DRAIN;
      DRAIN:  if (out_fire && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and status outputs, forced low while in reset.
  always_comb begin
    tri_ready = 1'b0;
    pix_ready = 1'b0;
    busy      = 1'b0;
    if (rst) begin
      tri_ready = (state == IDLE);
      pix_ready = (state == ACTIVE) && !stall;
      busy      = (state != IDLE);
    end
  end

  // Capture the offered triangle and its cull mode.
  always_ff @(posedge clk) begin
    if (tri_fire) begin
      ax    <= tri_data[6*CW-1 -: CW];
      ay    <= tri_data[5*CW-1 -: CW];
      bx    <= tri_data[4*CW-1 -: CW];
      by    <= tri_data[3*CW-1 -: CW];
      cx    <= tri_data[2*CW-1 -: CW];
      cy    <= tri_data[CW-1 -: CW];
      cmode <= cull_mode;
    end
  end

  assign sab_x = {bx[CW-1], bx} - {ax[CW-1], ax};
  assign sab_y = {by[CW-1], by} - {ay[CW-1], ay};
  assign sbc_x = {cx[CW-1], cx} - {bx[CW-1], bx};
  assign sbc_y = {cy[CW-1], cy} - {by[CW-1], by};
  assign sca_x = {ax[CW-1], ax} - {cx[CW-1], cx};
  assign sca_y = {ay[CW-1], ay} - {cy[CW-1], cy};
  assign nca_x = -{sca_x[DW-1], sca_x};
  assign nca_y = -{sca_y[DW-1], sca_y};

  assign area2 = AW'(sab_x) * AW'(nca_y) - AW'(sab_y) * AW'(nca_x);

  assign culled_c = ((cmode == 2'd1) && area2[AW-1]) ||
                    ((cmode == 2'd2) && !area2[AW-1] && (area2 != '0));

  // Latch per-triangle edge deltas and rejection flags during setup.
  always_ff @(posedge clk) begin
    if (state == SETUP) begin
      ab_x       <= sab_x;
      ab_y       <= sab_y;
      bc_x       <= sbc_x;
      bc_y       <= sbc_y;
      ca_x       <= sca_x;
      ca_y       <= sca_y;
      degenerate <= (area2 == '0);
      culled     <= culled_c;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [XW:0]          lx;
    logic signed [VW-1:0] px, py;
    logic signed [VW-1:0] bpx, bpy, cpx, cpy, apx, apy;
    logic signed [EW-1:0] e0, e1, e2;
    logic                 nonneg, nonpos;

    assign lx  = {1'b0, pix_x} + (XW+1)'(g);
    assign px  = VW'(lx);
    assign py  = VW'(pix_y);
    assign bpx = px - VW'(bx);
    assign bpy = py - VW'(by);
    assign cpx = px - VW'(cx);
    assign cpy = py - VW'(cy);
    assign apx = px - VW'(ax);
    assign apy = py - VW'(ay);

    assign prod[g][0] = PW'(ab_x) * PW'(bpy);
    assign prod[g][1] = PW'(ab_y) * PW'(bpx);
    assign prod[g][2] = PW'(bc_x) * PW'(cpy);
    assign prod[g][3] = PW'(bc_y) * PW'(cpx);
    assign prod[g][4] = PW'(ca_x) * PW'(apy);
    assign prod[g][5] = PW'(ca_y) * PW'(apx);

    assign e0 = EW'(s1_p[g][0]) - EW'(s1_p[g][1]);
    assign e1 = EW'(s1_p[g][2]) - EW'(s1_p[g][3]);
    assign e2 = EW'(s1_p[g][4]) - EW'(s1_p[g][5]);

    assign nonneg = !e0[EW-1] && !e1[EW-1] && !e2[EW-1];
    assign nonpos = (e0[EW-1] || (e0 == '0)) &&
                    (e1[EW-1] || (e1 == '0)) &&
                    (e2[EW-1] || (e2 == '0));

    assign inside_c[g] = s1_mask[g] && !degenerate && !culled &&
                         (nonneg || nonpos);
  end

  // Stage 1: register per-lane products and beat fields; hold on stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v <= 1'b0;
    end else if (!stall) begin
      s1_v <= pix_fire;
      if (pix_fire) begin
        s1_x    <= pix_x;
        s1_y    <= pix_y;
        s1_mask <= pix_mask;
        s1_last <= pix_last;
        for (int k = 0; k < LANES; k++) begin
          for (int j = 0; j < 6; j++) begin
            s1_p[k][j] <= prod[k][j];
          end
        end
      end
    end
  end

  // Stage 2: register the inside decision and output fields; hold on stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_inside <= '0;
      out_last   <= 1'b0;
    end else if (!stall) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_x      <= s1_x;
        out_y      <= s1_y;
        out_inside <= inside_c;
        out_last   <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_edge_test_array.sv
// Directed bench for edge_test_array.
// Linear script of triangle/beat steps with immediate assertions.
module tb_edge_test_array;

  localparam int LANES = 4;
  localparam int CW    = 16;
  localparam int XW    = 11;
  localparam int YW    = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             tri_valid;
  logic             tri_ready;
  logic [6*CW-1:0]  tri_data;
  logic [1:0]       cull_mode;
  logic             pix_valid;
  logic             pix_ready;
  logic [XW-1:0]    pix_x;
  logic [YW-1:0]    pix_y;
  logic [LANES-1:0] pix_mask;
  logic             pix_last;
  logic             out_valid;
  logic             out_ready;
  logic [XW-1:0]    out_x;
  logic [YW-1:0]    out_y;
  logic [LANES-1:0] out_inside;
  logic             out_last;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  edge_test_array #(
    .LANES(LANES), .CW(CW), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk), .rst(rst),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_data(tri_data), .cull_mode(cull_mode),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y),
    .pix_mask(pix_mask), .pix_last(pix_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y),
    .out_inside(out_inside), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6*CW-1:0] pk(int x1, int y1, int x2,
                                         int y2, int x3, int y3);
    return {16'(x1), 16'(y1), 16'(x2), 16'(y2), 16'(x3), 16'(y3)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_tri(input logic [6*CW-1:0] d, input logic [1:0] m);
    tri_data  = d;
    cull_mode = m;
    tri_valid = 1'b1;
    step();
    tri_valid = 1'b0;
    step();
  endtask

  task automatic set_pix(input int x, input int y, input logic [3:0] m,
                         input logic l);
    pix_valid = 1'b1;
    pix_x     = XW'(x);
    pix_y     = YW'(y);
    pix_mask  = m;
    pix_last  = l;
  endtask

  logic [6*CW-1:0] tri_ccw, tri_line, tri_cw;

  initial begin
    tri_ccw  = pk(0, 0, 8, 0, 0, 8);
    tri_line = pk(5, 0, 5, 4, 5, 9);
    tri_cw   = pk(0, 0, 0, 8, 8, 0);

    rst       = 1'b0;
    tri_valid = 1'b0;
    tri_data  = '0;
    cull_mode = 2'd0;
    pix_valid = 1'b0;
    pix_x     = '0;
    pix_y     = '0;
    pix_mask  = '0;
    pix_last  = 1'b0;
    out_ready = 1'b1;

    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_inside", out_inside, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_tri_ready", tri_ready, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    #1;
    chk("post_rst_tri_ready", tri_ready, 1);

    // Full-coverage beat at the origin corner.
    tri_data  = tri_ccw;
    cull_mode = 2'd0;
    tri_valid = 1'b1;
    step();
    tri_valid = 1'b0;
    chk("setup_busy", busy, 1);
    chk("setup_tri_ready", tri_ready, 0);
    chk("setup_pix_ready", pix_ready, 0);
    step();
    chk("active_pix_ready", pix_ready, 1);
    set_pix(0, 0, 4'b1111, 1'b1);
    step();
    pix_valid = 1'b0;
    chk("t31_lat1_valid", out_valid, 0);
    chk("t31_drain_ready", pix_ready, 0);
    step();
    chk("t31_valid", out_valid, 1);
    chk("t31_inside", out_inside, 4'b1111);
    chk("t31_last", out_last, 1);
    chk("t31_x", out_x, 0);
    step();
    chk("t31_busy_low", busy, 0);
    chk("t31_valid_low", out_valid, 0);
    chk("t31_tri_ready", tri_ready, 1);

    // Masked lanes straddling the hypotenuse.
    start_tri(tri_ccw, 2'd0);
    set_pix(6, 2, 4'b1011, 1'b1);
    step();
    pix_valid = 1'b0;
    step();
    chk("t32_valid", out_valid, 1);
    chk("t32_inside", out_inside, 4'b0001);
    chk("t32_x", out_x, 6);
    chk("t32_y", out_y, 2);
    step();
    chk("t32_busy_low", busy, 0);

    // Degenerate vertical line: beats emitted, nothing inside.
    start_tri(tri_line, 2'd0);
    set_pix(5, 3, 4'b1111, 1'b0);
    step();
    set_pix(4, 5, 4'b1111, 1'b1);
    step();
    pix_valid = 1'b0;
    chk("t33_b1_valid", out_valid, 1);
    chk("t33_b1_inside", out_inside, 0);
    chk("t33_b1_x", out_x, 5);
    chk("t33_b1_last", out_last, 0);
    step();
    chk("t33_b2_valid", out_valid, 1);
    chk("t33_b2_inside", out_inside, 0);
    chk("t33_b2_x", out_x, 4);
    chk("t33_b2_last", out_last, 1);
    step();
    chk("t33_busy_low", busy, 0);

    // Clockwise triangle culled under CCW-only mode.
    start_tri(tri_cw, 2'd1);
    set_pix(1, 1, 4'b1111, 1'b1);
    step();
    pix_valid = 1'b0;
    step();
    chk("t34_cull_valid", out_valid, 1);
    chk("t34_cull_inside", out_inside, 0);
    step();

    // Same triangle without culling: all-nonpositive edges count as inside.
    start_tri(tri_cw, 2'd0);
    set_pix(1, 1, 4'b1111, 1'b1);
    step();
    pix_valid = 1'b0;
    step();
    chk("t34_nocull_inside", out_inside, 4'b1111);
    step();

    // Backpressure: three beats offered, only two fit in the pipe.
    start_tri(tri_ccw, 2'd0);
    out_ready = 1'b0;
    set_pix(0, 0, 4'b1111, 1'b0);
    chk("t35_b1_ready", pix_ready, 1);
    step();
    set_pix(6, 2, 4'b1011, 1'b0);
    chk("t35_b2_ready", pix_ready, 1);
    step();
    set_pix(1, 1, 4'b1111, 1'b1);
    chk("t35_stall_ready0", pix_ready, 0);
    chk("t35_hold_valid0", out_valid, 1);
    chk("t35_hold_x0", out_x, 0);
    step();
    chk("t35_stall_ready1", pix_ready, 0);
    chk("t35_hold_x1", out_x, 0);
    chk("t35_hold_inside1", out_inside, 4'b1111);
    step();
    step();
    chk("t35_stall_ready3", pix_ready, 0);
    chk("t35_hold_x3", out_x, 0);
    chk("t35_hold_last3", out_last, 0);
    step();
    out_ready = 1'b1;
    #1;
    chk("t35_release_ready", pix_ready, 1);
    step();
    pix_valid = 1'b0;
    chk("t35_b2_valid", out_valid, 1);
    chk("t35_b2_x", out_x, 6);
    chk("t35_b2_inside", out_inside, 4'b0001);
    chk("t35_b2_last", out_last, 0);
    step();
    chk("t35_b3_valid", out_valid, 1);
    chk("t35_b3_x", out_x, 1);
    chk("t35_b3_y", out_y, 1);
    chk("t35_b3_inside", out_inside, 4'b1111);
    chk("t35_b3_last", out_last, 1);
    step();
    chk("t35_busy_low", busy, 0);
    chk("t35_valid_low", out_valid, 0);

    // Reset mid-triangle with two beats in flight.
    start_tri(tri_ccw, 2'd0);
    set_pix(0, 0, 4'b1111, 1'b0);
    step();
    set_pix(3, 3, 4'b1111, 1'b0);
    step();
    pix_valid = 1'b0;
    chk("t36_inflight_valid", out_valid, 1);
    rst = 1'b0;
    step();
    chk("t36_rst_valid", out_valid, 0);
    chk("t36_rst_busy", busy, 0);
    chk("t36_rst_tri_ready", tri_ready, 0);
    rst = 1'b1;
    #1;
    chk("t36_release_tri_ready", tri_ready, 1);
    step();
    chk("t36_no_stale0", out_valid, 0);
    step();
    chk("t36_no_stale1", out_valid, 0);
    start_tri(tri_ccw, 2'd0);
    set_pix(2, 5, 4'b0110, 1'b1);
    step();
    pix_valid = 1'b0;
    step();
    chk("t36_fresh_valid", out_valid, 1);
    chk("t36_fresh_x", out_x, 2);
    chk("t36_fresh_inside", out_inside, 4'b0010);
    step();
    chk("t36_fresh_busy_low", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
